// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the multi-cycle sequencer (master) and the MIPS-subset datapath (slave).
interface multicycle_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ir_write;
  logic             mem_read;
  logic             mem_write;
  logic             mem_addr_sel;
  logic             reg_write;
  logic             link_to_pc;
  logic             mem_to_reg;
  logic             alu_src;
  logic [2:0]       alu_command;
  logic [2:0]       state;
  logic             illegal;
  logic             bus_error;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, pc_src, ir_write, mem_read, mem_write, mem_addr_sel,
           reg_write, link_to_pc, mem_to_reg, alu_src, alu_command,
           state, illegal, bus_error, instret
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, pc_src, ir_write, mem_read, mem_write, mem_addr_sel,
           reg_write, link_to_pc, mem_to_reg, alu_src, alu_command,
           state, illegal, bus_error, instret
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB over a shared ALU and memory port,
// with retired-instruction counting and sticky illegal-encoding / memory-timeout traps.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_sequencer_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       op_q, fn_q;
  logic [7:0]       wait_q, wait_d;
  logic             illegal_q, bus_error_q;
  logic [CNT_W-1:0] instret_q;
  logic             retire, set_illegal, set_bus_error;

  logic       pc_write, ir_write, mem_read, mem_write, mem_addr_sel;
  logic       reg_write, link_to_pc, mem_to_reg, alu_src;
  logic [1:0] pc_src;
  logic [2:0] alu_command;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    case (op)
      OP_RTYPE: ok = (fn == FN_JR) || (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_SLT);
      OP_J, OP_JAL, OP_BNE, OP_ADDI, OP_XORI, OP_LW, OP_SW: ok = 1'b1;
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
    logic [2:0] cmd;
    case (fn)
      FN_SUB:  cmd = ALU_SUB;
      FN_SLT:  cmd = ALU_SLT;
      default: cmd = ALU_ADD;
    endcase
    return cmd;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      wait_q      <= 8'd0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
      instret_q   <= '0;
      op_q        <= 6'd0;
      fn_q        <= 6'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == DECODE) begin
        op_q <= bus.opcode;
        fn_q <= bus.funct;
      end
      if (set_illegal)   illegal_q   <= 1'b1;
      if (set_bus_error) bus_error_q <= 1'b1;
      if (retire)        instret_q   <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = 8'd0;
    retire        = 1'b0;
    set_illegal   = 1'b0;
    set_bus_error = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 2'b00;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_addr_sel  = 1'b0;
    reg_write     = 1'b0;
    link_to_pc    = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src       = 1'b0;
    alu_command   = ALU_ADD;

    case (state_q)
      FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == WAIT_LAST) begin
            set_bus_error = 1'b1;
            state_d       = TRAP;
          end
        end
      end
      DECODE: begin
        if (is_legal(bus.opcode, bus.funct)) state_d = EXEC;
        else begin
          set_illegal = 1'b1;
          state_d     = TRAP;
        end
      end
      EXEC: begin
        state_d = FETCH;
        case (op_q)
          OP_J: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            retire   = 1'b1;
          end
          OP_JAL: begin
            pc_write   = 1'b1;
            pc_src     = 2'b10;
            reg_write  = 1'b1;
            link_to_pc = 1'b1;
            retire     = 1'b1;
          end
          OP_BNE: begin
            alu_command = ALU_SUB;
            retire      = 1'b1;
            if (!bus.zero) begin
              pc_write = 1'b1;
              pc_src   = 2'b01;
            end
          end
          OP_RTYPE: begin
            if (fn_q == FN_JR) begin
              pc_write = 1'b1;
              pc_src   = 2'b11;
              retire   = 1'b1;
            end else begin
              alu_command = rtype_alu(fn_q);
              state_d     = WB;
            end
          end
          OP_ADDI: begin
            alu_src = 1'b1;
            state_d = WB;
          end
          OP_XORI: begin
            alu_src     = 1'b1;
            alu_command = ALU_XOR;
            state_d     = WB;
          end
          OP_LW, OP_SW: begin
            alu_src = 1'b1;
            state_d = MEM;
          end
          default: state_d = FETCH;
        endcase
      end
      MEM: begin
        mem_addr_sel = 1'b1;
        alu_src      = 1'b1;
        mem_read     = (op_q == OP_LW);
        mem_write    = (op_q == OP_SW);
        if (bus.mem_ready) begin
          if (op_q == OP_LW) state_d = WB;
          else begin
            retire  = 1'b1;
            state_d = FETCH;
          end
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == WAIT_LAST) begin
            set_bus_error = 1'b1;
            state_d       = TRAP;
          end
        end
      end
      WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
        if (op_q == OP_LW) mem_to_reg = 1'b1;
        else if (op_q == OP_RTYPE) alu_command = rtype_alu(fn_q);
        else if (op_q == OP_ADDI) alu_src = 1'b1;
        else if (op_q == OP_XORI) begin
          alu_src     = 1'b1;
          alu_command = ALU_XOR;
        end
      end
      default: state_d = TRAP;
    endcase

    // Reset aborts whatever is in flight: no strobe may reach the datapath this cycle.
    if (reset) begin
      pc_write     = 1'b0;
      pc_src       = 2'b00;
      ir_write     = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_addr_sel = 1'b0;
      reg_write    = 1'b0;
      link_to_pc   = 1'b0;
      mem_to_reg   = 1'b0;
      alu_src      = 1'b0;
      alu_command  = ALU_ADD;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.pc_src       = pc_src;
  assign bus.ir_write     = ir_write;
  assign bus.mem_read     = mem_read;
  assign bus.mem_write    = mem_write;
  assign bus.mem_addr_sel = mem_addr_sel;
  assign bus.reg_write    = reg_write;
  assign bus.link_to_pc   = link_to_pc;
  assign bus.mem_to_reg   = mem_to_reg;
  assign bus.alu_src      = alu_src;
  assign bus.alu_command  = alu_command;
  assign bus.state        = state_q;
  assign bus.illegal      = illegal_q;
  assign bus.bus_error    = bus_error_q;
  assign bus.instret      = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench: builds a per-cycle expected trace from instruction-level rules and compares every cycle.
module tb_multicycle_sequencer;
  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_sequencer_if #(.CNT_W(CNT_W)) bus();

  multicycle_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic             rst, ready, zero;
    logic [5:0]       op, fn;
    logic [2:0]       st;
    logic             pcw;
    logic [1:0]       pcs;
    logic             irw, mrd, mwr, mas, rw, lnk, m2r, asrc;
    logic [2:0]       alu;
    logic             ill, berr;
    logic [CNT_W-1:0] cnt;
  } rec_t;

  rec_t             q[$];
  rec_t             cur;
  logic             chkOn = 1'b0;
  logic [CNT_W-1:0] mCnt = '0;
  logic             mIll = 1'b0, mBerr = 1'b0;

  int    compared = 0, mismatched = 0;
  string litName[64];
  int    litGot[64], litWant[64];
  int    litPosted = 0, litDone = 0;
  logic [13:0] act;

  logic [5:0] legalOp[11] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h05, 6'h08, 6'h0e, 6'h23, 6'h2b};
  logic [5:0] legalFn[11] = '{6'h08, 6'h20, 6'h22, 6'h2a, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  function automatic logic [13:0] strobesOf(rec_t r);
    return {r.pcw, r.pcs, r.irw, r.mrd, r.mwr, r.mas, r.rw, r.lnk, r.m2r, r.asrc, r.alu};
  endfunction

  function automatic logic [2:0] aluOf(logic [5:0] fn);
    return (fn == 6'h22) ? 3'd1 : (fn == 6'h2a) ? 3'd2 : 3'd0;
  endfunction

  function automatic rec_t blank();
    rec_t r;
    r = '{default: '0};
    r.ready = 1'($urandom);
    r.zero  = 1'($urandom);
    r.op    = 6'($urandom);
    r.fn    = 6'($urandom);
    r.ill   = mIll;
    r.berr  = mBerr;
    r.cnt   = mCnt;
    return r;
  endfunction

  function automatic void retireOne();
    mCnt = mCnt + CNT_W'(1);
  endfunction

  task automatic checkOutput(input string name, input int got, input int want);
    litName[litPosted] = name;
    litGot[litPosted]  = got;
    litWant[litPosted] = want;
    litPosted++;
  endtask

  task automatic addReset(input logic [2:0] st);
    rec_t r;
    r = blank();
    r.rst = 1'b1;
    r.st  = st;
    q.push_back(r);
    mCnt = '0;
    mIll = 1'b0;
    mBerr = 1'b0;
  endtask

  task automatic addTrap(input int k);
    rec_t r;
    for (int i = 0; i < k; i++) begin
      r = blank();
      r.st = 3'd5;
      q.push_back(r);
    end
  endtask

  task automatic addTimeout(output int n);
    rec_t r;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      r = blank();
      r.mrd = 1'b1;
      r.ready = 1'b0;
      q.push_back(r);
    end
    mBerr = 1'b1;
    n = MEM_TIMEOUT;
  endtask

  // Expected trace for one instruction; cut >= 0 asserts reset on that MEM cycle instead.
  task automatic buildInstr(input logic [5:0] op, input logic [5:0] fn, input int dF, input int dM,
                            input logic z, input int cut, output int n);
    rec_t r;
    int n0 = q.size();
    logic legal, jr;
    legal = (op == 6'h00) ? (fn inside {6'h08, 6'h20, 6'h22, 6'h2a})
                          : (op inside {6'h02, 6'h03, 6'h05, 6'h08, 6'h0e, 6'h23, 6'h2b});
    jr = (op == 6'h00) && (fn == 6'h08);
    for (int i = 0; i <= dF; i++) begin
      r = blank();
      r.mrd = 1'b1;
      r.ready = (i == dF);
      r.irw = r.ready;
      r.pcw = r.ready;
      q.push_back(r);
    end
    r = blank(); r.op = op; r.fn = fn; r.st = 3'd1;
    q.push_back(r);
    if (!legal) begin
      mIll = 1'b1;
      n = q.size() - n0;
      return;
    end
    r = blank(); r.op = op; r.fn = fn; r.st = 3'd2; r.zero = z;
    case (op)
      6'h02: begin r.pcw = 1; r.pcs = 2; end
      6'h03: begin r.pcw = 1; r.pcs = 2; r.rw = 1; r.lnk = 1; end
      6'h05: begin r.alu = 1; if (!z) begin r.pcw = 1; r.pcs = 1; end end
      6'h00: if (jr) begin r.pcw = 1; r.pcs = 3; end else r.alu = aluOf(fn);
      6'h0e: begin r.asrc = 1; r.alu = 3; end
      default: r.asrc = 1;
    endcase
    q.push_back(r);
    if ((op inside {6'h02, 6'h03, 6'h05}) || jr) begin
      retireOne();
      n = q.size() - n0;
      return;
    end
    if (op inside {6'h23, 6'h2b}) begin
      for (int i = 0; i <= dM; i++) begin
        r = blank(); r.op = op; r.fn = fn; r.st = 3'd3;
        if (i == cut) begin
          r.rst = 1'b1;
          r.ready = 1'b1;
          q.push_back(r);
          mCnt = '0; mIll = 1'b0; mBerr = 1'b0;
          n = q.size() - n0;
          return;
        end
        r.mas = 1; r.asrc = 1;
        r.mrd = (op == 6'h23);
        r.mwr = (op == 6'h2b);
        r.ready = (i == dM);
        q.push_back(r);
      end
      if (op == 6'h2b) begin
        retireOne();
        n = q.size() - n0;
        return;
      end
    end
    r = blank(); r.op = op; r.fn = fn; r.st = 3'd4; r.rw = 1;
    if (op == 6'h23) r.m2r = 1;
    else if (op == 6'h00) r.alu = aluOf(fn);
    else if (op == 6'h08) r.asrc = 1;
    else if (op == 6'h0e) begin r.asrc = 1; r.alu = 3; end
    q.push_back(r);
    retireOne();
    n = q.size() - n0;
  endtask

  task automatic applyStimulus(input rec_t r);
    @(posedge clk);
    #1;
    reset         = r.rst;
    bus.opcode    = r.op;
    bus.funct     = r.fn;
    bus.zero      = r.zero;
    bus.mem_ready = r.ready;
    cur           = r;
    chkOn         = 1'b1;
  endtask

  // Single compare process: the per-cycle trace check plus any posted literal checks.
  always @(negedge clk) begin
    if (chkOn) begin
      compared++;
      act = {bus.pc_write, bus.pc_src, bus.ir_write, bus.mem_read, bus.mem_write, bus.mem_addr_sel,
             bus.reg_write, bus.link_to_pc, bus.mem_to_reg, bus.alu_src, bus.alu_command};
      if (bus.state !== cur.st || act !== strobesOf(cur) || bus.illegal !== cur.ill ||
          bus.bus_error !== cur.berr || bus.instret !== cur.cnt) begin
        mismatched++;
        $display("[TB] FAIL trace t=%0t: state got %0d want %0d, strobes got %h want %h, illegal got %b want %b, bus_error got %b want %b, instret got %0d want %0d",
                 $time, bus.state, cur.st, act, strobesOf(cur), bus.illegal, cur.ill,
                 bus.bus_error, cur.berr, bus.instret, cur.cnt);
      end
    end
    while (litDone < litPosted) begin
      compared++;
      if (litGot[litDone] != litWant[litDone]) begin
        mismatched++;
        $display("[TB] FAIL %s: got %0d want %0d", litName[litDone], litGot[litDone], litWant[litDone]);
      end
      litDone++;
    end
  end

  initial begin
    int n, k;
    reset = 1'b1;
    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_state", int'(bus.state), 0);
    checkOutput("reset_illegal", int'(bus.illegal), 0);
    checkOutput("reset_bus_error", int'(bus.bus_error), 0);
    checkOutput("reset_instret", int'(bus.instret), 0);
    checkOutput("reset_mem_read", int'(bus.mem_read), 0);

    buildInstr(6'h00, 6'h20, 0, 0, 1'b0, -1, n);
    checkOutput("add_cycles", n, 4);
    checkOutput("add_instret", int'(mCnt), 1);
    buildInstr(6'h23, 6'h00, 3, 2, 1'b0, -1, n);
    checkOutput("lw_cycles", n, 10);
    checkOutput("lw_instret", int'(mCnt), 2);
    buildInstr(6'h05, 6'h00, 0, 0, 1'b0, -1, n);
    checkOutput("bne_taken_pcsrc", int'(q[q.size()-1].pcs), 1);
    buildInstr(6'h05, 6'h00, 1, 0, 1'b1, -1, n);
    checkOutput("bne_not_taken_pcwrite", int'(q[q.size()-1].pcw), 0);
    buildInstr(6'h03, 6'h00, 0, 0, 1'b0, -1, n);
    checkOutput("jal_cycles", n, 3);
    buildInstr(6'h00, 6'h08, 0, 0, 1'b0, -1, n);
    checkOutput("jr_cycles", n, 3);
    checkOutput("jr_pcsrc", int'(q[q.size()-1].pcs), 3);
    checkOutput("instret_after_jr", int'(mCnt), 6);

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 10);
      buildInstr(legalOp[k], (k < 4) ? legalFn[k] : 6'($urandom), $urandom_range(0, 5),
                 $urandom_range(0, 5), 1'($urandom), -1, n);
    end

    buildInstr(6'h2b, 6'h00, 0, 5, 1'b0, 2, n);
    checkOutput("sw_abort_cycles", n, 6);
    buildInstr(6'h00, 6'h22, 2, 0, 1'b0, -1, n);
    checkOutput("instret_after_abort_sub", int'(mCnt), 1);

    buildInstr(6'h3f, 6'h00, 1, 0, 1'b0, -1, n);
    checkOutput("illegal_op_cycles", n, 3);
    addTrap(20);
    addReset(3'd5);
    buildInstr(6'h00, 6'h24, 0, 0, 1'b0, -1, n);
    addTrap(20);
    addReset(3'd5);

    addTimeout(n);
    addTrap(4);
    addReset(3'd5);
    buildInstr(6'h0e, 6'h00, 0, 0, 1'b0, -1, n);
    checkOutput("xori_cycles", n, 4);

    while (q.size() > 0) applyStimulus(q.pop_front());
    @(negedge clk);
    #1;
    chkOn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the single-issue MIPS-subset CPU.
- Sequences fetch, decode, execute, memory and writeback over one shared ALU and one shared instruction/data memory port.
- Replaces per-instruction combinational control with per-state control strobes.
- Counts retired instructions and traps on illegal encodings or memory timeouts.

Parameters:
- MEM_TIMEOUT, 16, max cycles a memory request may wait for mem_ready before bus-error trap (1..255).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instruction[31:26], valid from DECODE onward (IR held stable by this block's ir_write)
- funct  in  6  instruction[5:0]
- zero  in  1  ALU zero flag, sampled in EXEC
- mem_ready  in  1  memory handshake: access completes in the cycle it is high
- pc_write  out  1  PC register load strobe
- pc_src  out  2  PC mux select: 00 PC+4, 01 branch target, 10 jump target, 11 register Da
- ir_write  out  1  instruction register load strobe
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result (data)
- reg_write  out  1  register file write enable
- link_to_pc  out  1  write PC+4 to $31 (JAL)
- mem_to_reg  out  1  writeback data from memory
- alu_src  out  1  0 = Db, 1 = sign-extended immediate
- alu_command  out  3  ADD 000, SUB 001, SLT 010, XOR 011
- state  out  3  current state, for debug
- illegal  out  1  sticky: illegal opcode/funct trap
- bus_error  out  1  sticky: memory timeout trap
- instret  out  CNT_W  retired-instruction count

Behaviour:
- States: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 5.
- Reset (synchronous, active-high):
  - state = FETCH; illegal = bus_error = 0; instret = 0; wait counter = 0.
  - While reset is high, all strobes/requests are forced to 0 and alu_command = 000.
- Outputs are combinational from state, latched opcode/funct, mem_ready and zero.
- All strobes are 0 unless listed below for a state.
- FETCH:
  - mem_read = 1, mem_addr_sel = 0.
  - When mem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 00, go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE:
  - Latch opcode/funct internally; one cycle.
  - Legal encodings: opcodes 00, 02, 03, 05, 08, 0e, 23, 2b; funct for opcode 00: 08, 20, 22, 2a.
  - Illegal encoding -> TRAP with illegal = 1; otherwise go to EXEC.
- EXEC:
  - J: pc_write = 1, pc_src = 10; retire; go to FETCH.
  - JAL: same as J plus reg_write = 1, link_to_pc = 1.
  - JR (funct 08): pc_write = 1, pc_src = 11; retire; go to FETCH.
  - BNE: alu_command = SUB, alu_src = 0. If zero = 0: pc_write = 1, pc_src = 01. Retire either way; go to FETCH.
  - ADD/SUB/SLT: alu_command = ADD/SUB/SLT, alu_src = 0; go to WB.
  - ADDI/XORI: alu_command = ADD/XOR, alu_src = 1; go to WB.
  - LW/SW: alu_command = ADD, alu_src = 1; go to MEM.
- MEM:
  - mem_addr_sel = 1, alu_command = ADD, alu_src = 1.
  - LW: mem_read = 1. SW: mem_write = 1.
  - On mem_ready: LW goes to WB; SW retires and goes to FETCH.
  - Otherwise hold the request and increment the wait counter.
- WB:
  - reg_write = 1; one cycle.
  - mem_to_reg = 1 for LW; for R-type/ADDI/XORI, alu_command/alu_src are held as in EXEC.
  - Retire; go to FETCH.
- Retire: instret increments by 1 on the leaving edge; wraps to 0 at all-ones.
- Wait counter:
  - Clears on entry to FETCH or MEM, and on mem_ready.
  - If it reaches MEM_TIMEOUT with mem_ready still 0: bus_error = 1, go to TRAP. The request is dropped in TRAP.
- TRAP:
  - All strobes/requests are 0; PC and instret are frozen.
  - The only exit is reset.
- mem_ready outside FETCH/MEM is ignored.
- Reset asserted mid-instruction (any state, including a pending memory request) aborts it: no write strobe is asserted in that cycle and instret is not incremented.

Test Plan:
- ADD (op 00, funct 20), mem_ready = 1 in the fetch cycle: states 0-1-2-4-0 over 4 cycles; reg_write high exactly in WB; alu_command = 000; instret 0 -> 1.
- LW (op 23), mem_ready delayed 3 cycles in FETCH and 2 in MEM: mem_read held high throughout the waits; mem_to_reg = 1 and reg_write = 1 in WB; total 10 cycles; instret +1.
- BNE (op 05): with zero = 0, pc_write = 1 and pc_src = 01 in EXEC; with zero = 1, pc_write = 0. Both cases return to FETCH and instret +1.
- JAL (op 03) then JR (funct 08): JAL gives reg_write = link_to_pc = 1 and pc_src = 10 in EXEC; JR gives pc_src = 11 with reg_write = 0; 3 cycles each.
- Opcode 3f and, separately, R-type funct 24: TRAP after DECODE; illegal = 1; all strobes stay 0 for 20 cycles; reset returns to state 0 with illegal = 0.
- mem_ready held 0 in FETCH with MEM_TIMEOUT = 16: bus_error = 1 and state = 5 after 16 wait cycles. Second run: reset pulsed in MEM of a SW aborts it, mem_write drops to 0, instret unchanged.
